vga_sync_gen: RTL

//   Free-running VGA timing generator that is the upstream stage of the parallax renderer.
//   It produces hsync/vsync, the current beam position, a display-enable flag and

---
 rtl/vga_sync_gen.sv | 99 +++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: beam position, syncs, display enable and line/frame strobes.
// Every output is a flop decoded from next-state hpos/vpos, so all outputs line up with hpos/vpos.
module vga_sync_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_ce,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          display_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be in 1..16");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
        $error("vga_sync_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [3:0]    div_q;
    logic [3:0]    div_nxt;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_win;
    logic          vs_win;

    // pix_ce is the registered "divider is at its last count" flag; counters advance while it is high.
    always_comb begin
        div_nxt = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        h_wrap  = pix_ce && (hpos == H_LAST);
        v_wrap  = h_wrap && (vpos == V_LAST);
        h_nxt   = hpos;
        v_nxt   = vpos;
        if (pix_ce) h_nxt = h_wrap ? '0 : hpos + 1'b1;
        if (h_wrap) v_nxt = v_wrap ? '0 : vpos + 1'b1;
        hs_win  = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
        vs_win  = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= 4'd0;
            pix_ce      <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            display_on  <= 1'b1;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            div_q       <= div_nxt;
            pix_ce      <= (div_nxt == DIV_LAST);
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            display_on  <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            hsync       <= hs_win ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_win ? VSYNC_POL : ~VSYNC_POL;
            // Wraps only qualify on pix_ce cycles, so the strobes are one clk wide at any divide.
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
